// File: rtl/spi_resp.sv
// ---------------------------------------------------------------------------
// spi_resp -- full-duplex SPI responder (slave), SPI mode 0, MSB first.
//
// SCLK, MOSI and SS_n are oversampled on clk. One WIDTH-bit command is
// captured per frame while a response word is shifted out on MISO in the
// same frame. A completed command is flagged with a one-clk strobe.
//
// Optional feature macro: SPI_RESP_FRAME_ERR_EN
//   defined   : early SS_n release in a frame passes through ERR and pulses
//               o_frame_err for one clk.
//   undefined : early release returns straight to IDLE; o_frame_err is 0.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_sclk       SPI clock from master (idle low, asynchronous)
//   i_mosi       serial data from master, MSB first
//   i_ss_n       active-low select from master
//   i_tx_data    response word for the next frame
//   o_miso       serial data to master; high-Z while i_ss_n is high
//   o_rx_data    last complete command received
//   o_cmd_rdy    one-clk pulse: o_rx_data just updated
//   o_busy       high while a frame is in progress
//   o_frame_err  one-clk pulse: frame aborted early
// ---------------------------------------------------------------------------
module spi_resp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sclk,
  input  logic             i_mosi,
  input  logic             i_ss_n,
  input  logic [WIDTH-1:0] i_tx_data,
  output logic             o_miso,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_cmd_rdy,
  output logic             o_busy,
  output logic             o_frame_err
);

  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // [0] = first sync flop, [1] = second sync flop, [2] = edge-detect flop
  logic [2:0]       r_sclk_sync;
  logic [2:0]       r_ss_sync;
  logic [1:0]       r_mosi_sync;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_rx_sh;
  logic [WIDTH-1:0] r_tx_sh;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_cmd_rdy;
  logic             r_busy;

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ss_fall;
  logic w_ss_high;
  logic w_sample;
  logic w_word_done;
  logic w_clr_cnt;

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
  assign w_ss_high   = r_ss_sync[1];

  // Input synchronizers. SS_n resets low so that a select already held low
  // across reset never produces a falling edge; the master must re-select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= 3'b000;
      r_ss_sync   <= 3'b000;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
      r_ss_sync   <= {r_ss_sync[1:0], i_ss_n};
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath controls. The last rising edge wins over a
  // simultaneous SS_n release, so such a frame still completes.
  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_word_done = 1'b0;
    w_clr_cnt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = SHIFT;
          w_clr_cnt   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (w_sclk_rise && (r_bit_cnt == LAST_BIT)) begin
          w_sample    = 1'b1;
          w_word_done = 1'b1;
          w_state_nxt = DONE;
        end else if (w_ss_high) begin
`ifdef SPI_RESP_FRAME_ERR_EN
          w_state_nxt = ERR;
`else
          w_state_nxt = IDLE;
`endif
        end else if (w_sclk_rise) begin
          w_sample = 1'b1;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      DONE: begin
        if (w_ss_high) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      ERR: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bit counter and receive shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= {CW{1'b0}};
      r_rx_sh   <= {WIDTH{1'b0}};
    end else if (w_clr_cnt) begin
      r_bit_cnt <= {CW{1'b0}};
      r_rx_sh   <= r_rx_sh;
    end else if (w_sample) begin
      r_bit_cnt <= r_bit_cnt + CW'(1);
      r_rx_sh   <= {r_rx_sh[WIDTH-2:0], r_mosi_sync[1]};
    end else begin
      r_bit_cnt <= r_bit_cnt;
      r_rx_sh   <= r_rx_sh;
    end
  end

  // Completed word and its strobe; partial words never reach o_rx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data <= {WIDTH{1'b0}};
      r_cmd_rdy <= 1'b0;
    end else if (w_word_done) begin
      r_rx_data <= {r_rx_sh[WIDTH-2:0], r_mosi_sync[1]};
      r_cmd_rdy <= 1'b1;
    end else begin
      r_rx_data <= r_rx_data;
      r_cmd_rdy <= 1'b0;
    end
  end

  // Transmit shift register: tracks i_tx_data while idle, frozen once
  // selected. Falling edges keep shifting after the last bit so that MISO
  // drives zeros for any surplus clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sh <= {WIDTH{1'b0}};
    end else if (r_state == IDLE) begin
      r_tx_sh <= i_tx_data;
    end else if (w_sclk_fall && ((r_state == SHIFT) || (r_state == DONE))) begin
      r_tx_sh <= {r_tx_sh[WIDTH-2:0], 1'b0};
    end else begin
      r_tx_sh <= r_tx_sh;
    end
  end

  // Busy flag, registered from the next state so it matches the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
    end
  end

`ifdef SPI_RESP_FRAME_ERR_EN
  logic r_frame_err;

  // Error pulse, high for exactly the one clk spent in ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= (w_state_nxt == ERR);
    end
  end

  assign o_frame_err = r_frame_err;
`else
  assign o_frame_err = 1'b0;
`endif

  // Raw SS_n gates MISO: immediate bus release, and the first bit is on the
  // line as soon as the master selects us.
  assign o_miso    = i_ss_n ? 1'bz : r_tx_sh[WIDTH-1];
  assign o_rx_data = r_rx_data;
  assign o_cmd_rdy = r_cmd_rdy;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_spi_resp.sv
// ---------------------------------------------------------------------------
// tb_spi_resp -- self-checking bench for spi_resp (WIDTH = 16).
// A behavioural SPI master drives frames with a 32-clk SCLK period. The
// expected results come from the frame rules: a frame with at least WIDTH
// clock pulses delivers the first WIDTH MOSI bits as the command and the
// master sees the response word followed by zeros; a shorter frame leaves
// rx_data alone and (with SPI_RESP_FRAME_ERR_EN) raises one frame_err.
// MISO is given a pull-up so a released line reads as 1.
// ---------------------------------------------------------------------------
module tb_spi_resp;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sclk;
  logic         mosi;
  logic         ss_n;
  logic [W-1:0] tx_data;
  wire          miso;
  logic [W-1:0] rx_data;
  logic         cmd_rdy;
  logic         busy;
  logic         frame_err;

  pullup (miso);

  spi_resp #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sclk     (sclk),
    .i_mosi     (mosi),
    .i_ss_n     (ss_n),
    .i_tx_data  (tx_data),
    .o_miso     (miso),
    .o_rx_data  (rx_data),
    .o_cmd_rdy  (cmd_rdy),
    .o_busy     (busy),
    .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

`ifdef SPI_RESP_FRAME_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Observed event counts.
  int           cmd_cnt  = 0;
  int           err_cnt  = 0;
  int           stray_rx = 0;
  logic [W-1:0] last_rx  = '0;

  // Reference model state.
  logic [W-1:0] e_rx   = '0;
  int           e_cmds = 0;
  int           e_errs = 0;

  // Count strobes and catch any rx_data change that is not announced.
  always @(negedge clk) begin
    if (cmd_rdy === 1'b1) cmd_cnt <= cmd_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if (rst_n && (rx_data !== last_rx) && (cmd_rdy !== 1'b1)) stray_rx <= stray_rx + 1;
    last_rx <= rx_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive npulses SCLK pulses; bits past WIDTH send a 1 on MOSI.
  task automatic spi_bits(input logic [W-1:0] word, input int npulses,
                          input bit ss_rise_on_last, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < npulses; i++) begin
      mosi = (i < W) ? word[W-1-i] : 1'b1;
      tick(16);
      sclk = 1'b1;
      if (ss_rise_on_last && (i == npulses - 1)) ss_n = 1'b1;
      tick(16);
      got  = {got[30:0], miso};
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [W-1:0] cmd,
                           input logic [W-1:0] resp, input int npulses,
                           input bit sim_end);
    logic [31:0] got;
    logic [31:0] e_got;
    tx_data = resp;
    tick(2);
    ss_n = 1'b0;
    tick(6);
    check($sformatf("%s.miso_first", tag), miso, resp[W-1]);
    check($sformatf("%s.busy_mid", tag), busy, 1'b1);
    check($sformatf("%s.rx_hold", tag), rx_data, e_rx);
    spi_bits(cmd, npulses, sim_end, got);
    if (!sim_end) begin
      tick(6);
      ss_n = 1'b1;
      #1;
      check($sformatf("%s.miso_release", tag), miso, 1'b1);
    end
    tick(8);
    // Model: complete frames deliver the command, short ones are discarded.
    if (npulses >= W) begin
      e_rx = cmd;
      e_cmds++;
    end else begin
      e_errs += ERR_EN;
    end
    e_got = '0;
    for (int i = 0; i < npulses; i++) e_got = {e_got[30:0], (i < W) ? resp[W-1-i] : 1'b0};
    check($sformatf("%s.rx_data", tag), rx_data, e_rx);
    check($sformatf("%s.cmd_cnt", tag), cmd_cnt, e_cmds);
    check($sformatf("%s.err_cnt", tag), err_cnt, e_errs);
    check($sformatf("%s.busy_end", tag), busy, 1'b0);
    if (!sim_end) check($sformatf("%s.master_rx", tag), got, e_got);
  endtask

  initial begin
    logic [31:0] junk;
    int          np;
    rst_n   = 1'b0;
    sclk    = 1'b0;
    mosi    = 1'b0;
    ss_n    = 1'b1;
    tx_data = '0;
    tick(3);
    check("reset.rx_data", rx_data, 16'h0000);
    check("reset.cmd_rdy", cmd_rdy, 1'b0);
    check("reset.busy", busy, 1'b0);
    check("reset.frame_err", frame_err, 1'b0);
    check("reset.miso_z", miso, 1'b1);
    rst_n = 1'b1;
    tick(4);

    run_frame("basic", 16'h70C3, 16'h12EF, W, 1'b0);
    run_frame("b2b", 16'hDEAD, 16'hBEEF, W, 1'b0);
    run_frame("abort7", 16'h5A3C, 16'h7E81, 7, 1'b0);
    run_frame("over17", 16'hA5A5, 16'h0001, W + 1, 1'b0);
    run_frame("abort0", 16'hFFFF, 16'h8000, 0, 1'b0);
    run_frame("sim_end", 16'h3C3C, 16'h4321, W, 1'b1);

    // Reset in the middle of a frame with SS_n held low.
    tx_data = 16'h9999;
    tick(2);
    ss_n = 1'b0;
    tick(6);
    spi_bits(16'hF0F0, 5, 1'b0, junk);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    e_rx  = '0;
    tick(2);
    check("rst_mid.rx_data", rx_data, 16'h0000);
    check("rst_mid.busy", busy, 1'b0);
    spi_bits(16'hFFFF, W, 1'b0, junk);
    tick(6);
    check("rst_mid.no_cmd", cmd_cnt, e_cmds);
    check("rst_mid.no_busy", busy, 1'b0);
    check("rst_mid.rx_keep", rx_data, 16'h0000);
    ss_n = 1'b1;
    tick(8);
    run_frame("rst_recover", 16'h1234, 16'hC0DE, W, 1'b0);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0:       np = W;
        1:       np = W + 1;
        2:       np = $urandom_range(1, W - 1);
        default: np = W;
      endcase
      run_frame($sformatf("rand%0d", k), W'($urandom), W'($urandom), np, 1'b0);
    end

    check("stray_rx_change", stray_rx, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_resp.md
# spi_resp

Full-duplex SPI responder (slave) that terminates the 16-bit SPI master link inside the same clock domain. It oversamples SCLK, MOSI and SS_n on clk and captures one WIDTH-bit command per frame. In the same frame it shifts a response word out on MISO. A completed command is presented with a one-cycle strobe. MISO is tri-stated whenever the responder is not selected, so several responders can share one MISO line.

## Interface
- WIDTH, 16, frame length in bits; legal range 2..32.

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- SCLK  in  1  SPI clock from master, idle low, asynchronous to clk
- MOSI  in  1  serial data from master, MSB first
- SS_n  in  1  active-low select from master
- tx_data  in  WIDTH  response word for the next frame
- MISO  out  1  serial data to master, MSB first; 1'bz when SS_n high
- rx_data  out  WIDTH  last complete command received
- cmd_rdy  out  1  one-clk pulse: rx_data just updated
- busy  out  1  high while a frame is in progress (state != IDLE)
- frame_err  out  1  one-clk pulse: frame aborted early (see Configuration)

## Operation
- Input synchronizers: SCLK, MOSI and SS_n each pass through 2 flops, plus a third flop for edge detection.
  - SCLK and MOSI sync flops reset to 0.
  - SS_n sync flops reset to 0, so no false select edge follows reset.
  - sclk_rise = FF2 & ~FF3. sclk_fall = ~FF2 & FF3. ss_fall = ~FF2 & FF3 on SS_n.
- State machine, 2-bit:
  - IDLE: the TX shift register loads tx_data every clk. ss_fall -> SHIFT, clearing bit_cnt and freezing the TX shift register.
  - SHIFT:
    - sclk_rise: RX shift register <= {rx_sh[WIDTH-2:0], MOSI_sync}, and bit_cnt++.
    - sclk_fall: TX shift register shifts left, with a 0 entering at the LSB.
    - sclk_rise with bit_cnt==WIDTH-1: rx_data <= the completed word, cmd_rdy=1 for one clk, -> DONE.
    - Synchronized SS_n high before that point -> ERR.
  - DONE: all further SCLK edges are ignored; no sampling and no counting. Synchronized SS_n high -> IDLE.
  - ERR: frame_err=1 for one clk, -> IDLE. The partial word is discarded and rx_data is unchanged.
- MISO = SS_n (raw, unsynchronized) ? 1'bz : tx_sh[WIDTH-1]. Using raw SS_n gives immediate bus release and a first bit valid as soon as SS_n falls.
- After WIDTH falling edges, MISO drives 0 until SS_n rises.
- bit_cnt is $clog2(WIDTH)+1 bits wide and is never compared past WIDTH-1, so there is no wrap.
- Reset mid-frame:
  - All state returns to IDLE and the partial frame is lost.
  - Because SS_n sync resets low, a frame already in progress is not re-entered. The master must raise and re-lower SS_n.
- Simultaneous SS_n rise and last sclk_rise in the same clk: the frame completes (cmd_rdy fires) and frame_err stays 0.
- Reset values: rx_data=0, cmd_rdy=0, busy=0, frame_err=0, tx_sh=0. MISO follows the rule above.

## Timing
- SCLK high and low phases must each be ≥4 clk; the SPI master's 16/16 phases qualify.
- SS_n fall to the first SCLK rise: ≥4 clk.
- MOSI is sampled 3 clk after the actual SCLK rise.
- MISO changes 3 clk after the actual SCLK fall. The master samples MISO before its falling edge, so it sees stable data.
- cmd_rdy latency: asserted on the clk edge 3 clk after the WIDTH-th actual SCLK rise. rx_data is valid in the same cycle and holds until the next cmd_rdy.
- busy rises 3 clk after SS_n falls. It falls 3 clk after SS_n rises, plus one clk through ERR on the error path.
- tx_data must be stable by the clk on which ss_fall is detected.

## Configuration
- SPI_RESP_FRAME_ERR_EN defined: ERR state and early-abort detection are compiled in, and frame_err pulses as described.
- Undefined: frame_err is tied to 0. An early SS_n rise in SHIFT goes directly to IDLE, silently discarding the partial word; rx_data is still unchanged and cmd_rdy is not asserted.

## Test plan
- Master-compatible frame (32-clk SCLK period), master sends 0x70C3, tx_data=0x12EF -> rx_data=0x70C3 with one cmd_rdy pulse, and master captures 0x12EF.
- Back-to-back frames 0xDEAD/0xBEEF right after the first -> rx_data=0xDEAD and master receives 0xBEEF. rx_data holds 0x70C3 until the second cmd_rdy.
- SS_n raised after 7 SCLK pulses:
  - With the macro: frame_err pulses once, there is no cmd_rdy, and rx_data stays at its prior value.
  - Without the macro: frame_err stays 0, with the same lack of cmd_rdy and retained rx_data.
- 17 SCLK pulses in one frame with MOSI=0xA5A5 then a 1 -> rx_data=0xA5A5, a single cmd_rdy, and MISO=0 on the 17th bit.
- rst_n asserted mid-frame with SS_n held low, then released -> no cmd_rdy until SS_n toggles high then low. The following full frame 0x1234 is received correctly.
- SS_n high at any time -> MISO==1'bz within the same delta. SS_n low -> MISO==tx_data[15] before the first SCLK rise.
